pipe_reg_elastic: RTL and testbench
===================================

Name: pipe_reg_elastic

Overview:
- Parametrised successor to the fixed inter-stage pipeline registers, e.g. between EX and MEM.
- Carries one data bundle and one control bundle per transaction through a 2-entry elastic buffer (main register plus skid register) with valid/ready handshake.
- Adds stall via backpressure, synchronous flush (bubble insertion) and occupancy reporting, which the fixed registers lack.
- One instance is dropped between any two pipeline stages.

Parameters:
- DATA_W, 32, width of datapath bundle (PC+imm, ALU result, rs2 data, rd index, etc. packed by instantiator)
- CTRL_W, 12, width of control bundle (regwrite, memtoreg, memwrite, memread, branch, jal, jalr, ...)

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-low reset
- in_valid  input  1  upstream has a transaction
- in_ready  output  1  buffer can accept; = (count != 2), derived from registered state only
- in_data  input  DATA_W  upstream datapath bundle
- in_ctrl  input  CTRL_W  upstream control bundle
- flush  input  1  synchronous kill of all held and incoming transactions
- out_valid  output  1  main register holds a transaction
- out_ready  input  1  downstream accepts
- out_data  output  DATA_W  main register data
- out_ctrl  output  CTRL_W  main register control, forced to 0 when out_valid=0
- count  output  2  occupancy 0..2

Behaviour:
- Definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Reset (rst=0, async):
  - main/skid data and ctrl = 0; both valid bits = 0; count = 0.
  - Outputs: out_valid=0, out_data=0, out_ctrl=0, in_ready=1.
  - Reset mid-operation discards everything immediately, without waiting for a clock edge.
- States, encoded by count:
  - EMPTY (0): main invalid, skid invalid.
  - ONE (1): main valid, skid invalid.
  - FULL (2): main valid, skid valid.
- Transitions at posedge clk, flush=0:
  - EMPTY: in_fire -> main<=in, ONE; else stay.
  - ONE: in_fire & out_fire -> main<=in, ONE. in_fire only -> skid<=in, FULL. out_fire only -> EMPTY. Neither -> hold.
  - FULL: in_ready=0, so in_fire is impossible. out_fire -> main<=skid, skid invalid, ONE. Else hold.
- Latency: in_fire at edge N gives out_valid=1 after edge N (one cycle). Throughput is one transaction per cycle when out_ready=1.
- Ordering: strict FIFO; no transaction duplicated or lost except by flush or reset.
- Flush (flush=1 at posedge), highest priority over all transitions:
  - count<=0; main and skid valid <= 0; main and skid ctrl <= 0; data registers retain their values.
  - Any in_fire in the same cycle is discarded. in_ready is still (count!=2) for that cycle, so upstream sees a handshake but the transaction is dropped by design.
  - out_fire in the flush cycle is still a valid downstream consume.
  - After flush: out_valid=0, out_ctrl=0, in_ready=1.
- Output gating:
  - out_data = main data register and holds its last value when invalid.
  - out_ctrl = out_valid ? main ctrl : 0, so downstream sees NOP controls on a bubble.
- Invariants:
  - skid valid implies main valid.
  - count == main_valid + skid_valid.
  - in_ready never depends combinationally on out_ready.
- X-safety: when in_valid=0, no register updates from in_data/in_ctrl.

Test Plan:
- Reset: hold rst=0 with in_valid=1, in_data=32'hDEAD_BEEF. -> out_valid=0, out_data=0, out_ctrl=0, count=0, in_ready=1. After release with no clock edge, outputs unchanged.
- Streaming: out_ready=1; send data 1,2,3,4 with ctrl 12'h001..12'h004 on consecutive cycles. -> each appears exactly one cycle later, in order, count=1 throughout, in_ready=1.
- Backpressure: out_ready=0; send A=32'hA, then B=32'hB. -> count=2, in_ready=0, out_data=A. Hold 3 cycles: stable. Raise out_ready: A, then B, then out_valid=0, count=0.
- Flush when full: state FULL (A,B), assert flush with in_valid=1, in_data=32'hC. -> next cycle count=0, out_valid=0, out_ctrl=0, in_ready=1; C never appears at output.
- Simultaneous in/out in ONE: main=A, in_fire D and out_fire in same cycle. -> main=D, count=1, A consumed once, no skid use.
- Reset mid-operation: state FULL, drop rst asynchronously between edges. -> out_valid=0, count=0 immediately. After release, a new transaction E passes with 1-cycle latency.

Source files
------------

// File: rtl/pipe_reg_elastic_if.sv
// Handshake bundle for one elastic pipeline register.
// The master drives the upstream side plus out_ready/flush; the slave is the buffer itself.
interface pipe_reg_elastic_if #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 12
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic [1:0]        count;

    modport master (
        output in_valid, in_data, in_ctrl, flush, out_ready,
        input  in_ready, out_valid, out_data, out_ctrl, count
    );

    modport slave (
        input  in_valid, in_data, in_ctrl, flush, out_ready,
        output in_ready, out_valid, out_data, out_ctrl, count
    );
endinterface

// File: rtl/pipe_reg_elastic.sv
// Two-entry elastic pipeline register (main + skid) with valid/ready, flush and occupancy.
// State | meaning
// EMPTY | main invalid, skid invalid (count 0)
// ONE   | main valid, skid invalid   (count 1)
// FULL  | main valid, skid valid     (count 2), in_ready low
module pipe_reg_elastic #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 12
) (
    input  logic               clk,
    input  logic               rst,
    pipe_reg_elastic_if.slave  bus
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;

    logic main_valid;
    logic in_ready;
    logic in_fire;
    logic out_fire;

    // Ready comes from registered state only, so no out_ready -> in_ready path exists.
    assign main_valid = (state_q != EMPTY);
    assign in_ready   = (state_q != FULL);
    assign in_fire    = bus.in_valid & in_ready;
    assign out_fire   = main_valid & bus.out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= EMPTY;
            main_data_q <= '0;
            main_ctrl_q <= '0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_ctrl_q <= main_ctrl_d;
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;

        if (bus.flush) begin
            // Kill everything; data is left alone so the datapath does not toggle.
            state_d     = EMPTY;
            main_ctrl_d = '0;
            skid_ctrl_d = '0;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        main_data_d = bus.in_data;
                        main_ctrl_d = bus.in_ctrl;
                        state_d     = ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_data_d = bus.in_data;
                        main_ctrl_d = bus.in_ctrl;
                    end else if (in_fire) begin
                        skid_data_d = bus.in_data;
                        skid_ctrl_d = bus.in_ctrl;
                        state_d     = FULL;
                    end else if (out_fire) begin
                        state_d     = EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        main_data_d = skid_data_q;
                        main_ctrl_d = skid_ctrl_q;
                        skid_ctrl_d = '0;
                        state_d     = ONE;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = main_valid;
    assign bus.out_data  = main_data_q;
    assign bus.out_ctrl  = main_valid ? main_ctrl_q : '0;
    assign bus.count     = state_q;

endmodule

// File: tb/tb_pipe_reg_elastic.sv
// Self-checking bench for pipe_reg_elastic against a queue-based reference model.
module tb_pipe_reg_elastic;

    localparam int DW = 32;
    localparam int CW = 12;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [CW-1:0] ctrl;
    } txn_t;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    txn_t          mq[$];
    logic [DW-1:0] head_data;

    pipe_reg_elastic_if #(.DATA_W(DW), .CTRL_W(CW)) bus ();

    pipe_reg_elastic #(.DATA_W(DW), .CTRL_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [47:0] obs;
    assign obs = {bus.out_valid, bus.in_ready, bus.count, bus.out_data, bus.out_ctrl};

    function automatic logic [47:0] model_vec();
        logic [CW-1:0] c;
        logic [1:0]    n;
        c = (mq.size() != 0) ? mq[0].ctrl : '0;
        n = 2'(mq.size());
        return {(mq.size() != 0), (mq.size() != 2), n, head_data, c};
    endfunction

    task automatic model_reset();
        mq.delete();
        head_data = '0;
    endtask

    // Drive one cycle of inputs, advance the model across the edge, settle 1 time unit after it.
    task automatic step(input logic iv, input logic [DW-1:0] d, input logic [CW-1:0] c,
                        input logic ordy, input logic fl);
        bit inf, outf;
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.in_ctrl   = c;
        bus.out_ready = ordy;
        bus.flush     = fl;
        inf  = iv && (mq.size() != 2);
        outf = (mq.size() != 0) && ordy;
        @(posedge clk);
        if (fl) begin
            mq.delete();
        end else begin
            if (outf) void'(mq.pop_front());
            if (inf) mq.push_back(txn_t'{data: d, ctrl: c});
        end
        if (mq.size() != 0) head_data = mq[0].data;
        #1;
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
    endtask

    task automatic test_reset();
        rst           = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'hDEAD_BEEF;
        bus.in_ctrl   = 12'hFFF;
        bus.out_ready = 1'b0;
        bus.flush     = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (obs !== model_vec()) begin
            errors++;
            $display("FAIL reset_hold got=%h exp=%h", obs, model_vec());
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        checks++;
        if (obs !== model_vec()) begin
            errors++;
            $display("FAIL reset_release got=%h exp=%h", obs, model_vec());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_streaming();
        for (int i = 1; i <= 4; i++) begin
            step(1'b1, DW'(i), CW'(i), 1'b1, 1'b0);
            checks++;
            if (obs !== model_vec() || bus.out_data !== DW'(i) || bus.count !== 2'd1) begin
                errors++;
                $display("FAIL stream[%0d] got=%h exp=%h", i, obs, model_vec());
            end
        end
        step(1'b0, '0, '0, 1'b1, 1'b0);
        checks++;
        if (obs !== model_vec() || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stream_drain got=%h exp=%h", obs, model_vec());
        end
    endtask

    task automatic test_backpressure();
        step(1'b1, 32'hA, 12'h0A1, 1'b0, 1'b0);
        step(1'b1, 32'hB, 12'h0B2, 1'b0, 1'b0);
        checks++;
        if (obs !== model_vec() || bus.count !== 2'd2 || bus.in_ready !== 1'b0
            || bus.out_data !== 32'hA) begin
            errors++;
            $display("FAIL bp_full got=%h exp=%h", obs, model_vec());
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 32'h5555, 12'h555, 1'b0, 1'b0);
            checks++;
            if (obs !== model_vec()) begin
                errors++;
                $display("FAIL bp_hold[%0d] got=%h exp=%h", i, obs, model_vec());
            end
        end
        step(1'b0, '0, '0, 1'b1, 1'b0);
        checks++;
        if (obs !== model_vec() || bus.out_data !== 32'hB || bus.count !== 2'd1) begin
            errors++;
            $display("FAIL bp_drain_b got=%h exp=%h", obs, model_vec());
        end
        step(1'b0, '0, '0, 1'b1, 1'b0);
        checks++;
        if (obs !== model_vec() || bus.count !== 2'd0 || bus.out_ctrl !== 12'h0) begin
            errors++;
            $display("FAIL bp_empty got=%h exp=%h", obs, model_vec());
        end
    endtask

    task automatic test_flush_full();
        step(1'b1, 32'hA, 12'h0A1, 1'b0, 1'b0);
        step(1'b1, 32'hB, 12'h0B2, 1'b0, 1'b0);
        step(1'b1, 32'hC, 12'h0C3, 1'b0, 1'b1);
        checks++;
        if (obs !== model_vec() || bus.count !== 2'd0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_full got=%h exp=%h", obs, model_vec());
        end
        for (int i = 0; i < 2; i++) begin
            step(1'b0, '0, '0, 1'b1, 1'b0);
            checks++;
            if (obs !== model_vec() || bus.out_data === 32'hC) begin
                errors++;
                $display("FAIL flush_after[%0d] got=%h exp=%h", i, obs, model_vec());
            end
        end
    endtask

    task automatic test_simultaneous();
        step(1'b1, 32'hA, 12'h0A1, 1'b0, 1'b0);
        step(1'b1, 32'hD, 12'h0D4, 1'b1, 1'b0);
        checks++;
        if (obs !== model_vec() || bus.out_data !== 32'hD || bus.count !== 2'd1) begin
            errors++;
            $display("FAIL simul_swap got=%h exp=%h", obs, model_vec());
        end
        step(1'b0, '0, '0, 1'b1, 1'b0);
        checks++;
        if (obs !== model_vec() || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL simul_drain got=%h exp=%h", obs, model_vec());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            logic iv, ordy, fl;
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 2) != 0);
            fl   = ($urandom_range(0, 15) == 0);
            step(iv, DW'($urandom), CW'($urandom), ordy, fl);
            checks++;
            if (obs !== model_vec()) begin
                errors++;
                $display("FAIL random[%0d] got=%h exp=%h", i, obs, model_vec());
            end
        end
        step(1'b0, '0, '0, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid();
        step(1'b1, 32'h11, 12'h011, 1'b0, 1'b0);
        step(1'b1, 32'h22, 12'h022, 1'b0, 1'b0);
        #3 rst = 1'b0;
        model_reset();
        #1;
        checks++;
        if (obs !== model_vec() || bus.out_valid !== 1'b0 || bus.count !== 2'd0) begin
            errors++;
            $display("FAIL reset_mid got=%h exp=%h", obs, model_vec());
        end
        #2 rst = 1'b1;
        #1;
        step(1'b1, 32'hE, 12'h0E5, 1'b1, 1'b0);
        checks++;
        if (obs !== model_vec() || bus.out_data !== 32'hE || bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_e got=%h exp=%h", obs, model_vec());
        end
        step(1'b0, '0, '0, 1'b1, 1'b0);
        checks++;
        if (obs !== model_vec()) begin
            errors++;
            $display("FAIL reset_mid_drain got=%h exp=%h", obs, model_vec());
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush_full();
        test_simultaneous();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
